// File: rtl/glitch_sweep_ctrl.sv
// Purpose: automated glitch delay sweep; arms on target trigger, fires injector, watches for success.
// Latency: trigger rise sampled at edge N -> INJ_FIRE in cycle after N+3; INJ_BUSY low at M -> OBSERVE from M+1.
// Backpressure: INJ_BUSY holds the sweep in WAIT_INJ; RESET and ABORT preempt every state.
module glitch_sweep_ctrl #(
  parameter int DELAY_W     = 10,
  parameter int STEP        = 1,
  parameter int RESP_WINDOW = 5000000,
  parameter int ATT_W       = 16
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic               START,
  input  logic               ABORT,
  input  logic [DELAY_W-1:0] DELAY_MIN,
  input  logic [DELAY_W-1:0] DELAY_MAX,
  input  logic               TARGET_TRIG,
  input  logic               TARGET_OK,
  input  logic               INJ_BUSY,
  output logic [DELAY_W-1:0] INJ_DELAY,
  output logic               INJ_FIRE,
  output logic               BUSY,
  output logic               DONE,
  output logic               FOUND,
  output logic [DELAY_W-1:0] FOUND_DELAY,
  output logic [ATT_W-1:0]   ATTEMPTS
);

  localparam int WIN_W = $clog2(RESP_WINDOW + 1);
  localparam logic [DELAY_W:0]   STEP_X   = (DELAY_W+1)'(STEP);
  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(RESP_WINDOW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FIRE,
    S_GUARD,
    S_WAIT_INJ,
    S_OBSERVE
  } state_t;

  state_t state, state_n;

  logic               trig_s1, trig_s2, trig_s3, trig_rise;
  logic               ok_s1, ok_s2;

  logic [DELAY_W-1:0] inj_delay_q, inj_delay_n;
  logic [ATT_W-1:0]   attempts_q, attempts_n;
  logic               done_q, done_n;
  logic               found_q, found_n;
  logic [DELAY_W-1:0] found_delay_q, found_delay_n;
  logic               guard_cnt_q, guard_cnt_n;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_n;

  // Next delay is formed one bit wider so a large STEP clamps to DELAY_MAX instead of wrapping.
  logic [DELAY_W:0]   delay_sum;
  logic [DELAY_W-1:0] delay_step;

  assign delay_sum  = {1'b0, inj_delay_q} + STEP_X;
  assign delay_step = (delay_sum > {1'b0, DELAY_MAX}) ? DELAY_MAX : delay_sum[DELAY_W-1:0];

  // Two-flop synchronizers for the async target lines; the trigger rise pulse is registered,
  // which costs one cycle but keeps the pulse clean of the synchronizer output path.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      trig_s1   <= 1'b0;
      trig_s2   <= 1'b0;
      trig_s3   <= 1'b0;
      trig_rise <= 1'b0;
      ok_s1     <= 1'b0;
      ok_s2     <= 1'b0;
    end else begin
      trig_s1   <= TARGET_TRIG;
      trig_s2   <= trig_s1;
      trig_s3   <= trig_s2;
      trig_rise <= trig_s2 & ~trig_s3;
      ok_s1     <= TARGET_OK;
      ok_s2     <= ok_s1;
    end
  end

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_n;
  end

  // Sweep datapath registers: delay, attempt count, result flags and the two local counters.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      inj_delay_q   <= '0;
      attempts_q    <= '0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      found_delay_q <= '0;
      guard_cnt_q   <= 1'b0;
      win_cnt_q     <= '0;
    end else begin
      inj_delay_q   <= inj_delay_n;
      attempts_q    <= attempts_n;
      done_q        <= done_n;
      found_q       <= found_n;
      found_delay_q <= found_delay_n;
      guard_cnt_q   <= guard_cnt_n;
      win_cnt_q     <= win_cnt_n;
    end
  end

  // Next-state and datapath updates; ABORT at the end overrides everything but the held results.
  always_comb begin
    state_n       = state;
    inj_delay_n   = inj_delay_q;
    attempts_n    = attempts_q;
    done_n        = done_q;
    found_n       = found_q;
    found_delay_n = found_delay_q;
    guard_cnt_n   = guard_cnt_q;
    win_cnt_n     = win_cnt_q;

    case (state)
      S_IDLE: begin
        if (START) begin
          if (DELAY_MIN <= DELAY_MAX) begin
            inj_delay_n   = DELAY_MIN;
            attempts_n    = '0;
            found_n       = 1'b0;
            found_delay_n = '0;
            done_n        = 1'b0;
            state_n       = S_ARM;
          end else begin
            // Empty range: report an immediate unsuccessful finish.
            done_n     = 1'b1;
            found_n    = 1'b0;
            attempts_n = '0;
          end
        end
      end
      S_ARM: begin
        if (trig_rise) state_n = S_FIRE;
      end
      S_FIRE: begin
        if (attempts_q != '1) attempts_n = attempts_q + ATT_W'(1);
        guard_cnt_n = 1'b0;
        state_n     = S_GUARD;
      end
      S_GUARD: begin
        // INJ_BUSY may not be up yet right after the strobe, so it is not looked at here.
        if (guard_cnt_q) state_n = S_WAIT_INJ;
        else             guard_cnt_n = 1'b1;
      end
      S_WAIT_INJ: begin
        if (!INJ_BUSY) begin
          win_cnt_n = '0;
          state_n   = S_OBSERVE;
        end
      end
      S_OBSERVE: begin
        if (ok_s2) begin
          found_n       = 1'b1;
          found_delay_n = inj_delay_q;
          done_n        = 1'b1;
          state_n       = S_IDLE;
        end else if (win_cnt_q == WIN_LAST) begin
          if (inj_delay_q == DELAY_MAX) begin
            done_n  = 1'b1;
            found_n = 1'b0;
            state_n = S_IDLE;
          end else begin
            inj_delay_n = delay_step;
            state_n     = S_ARM;
          end
        end else begin
          win_cnt_n = win_cnt_q + WIN_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (ABORT) begin
      state_n       = S_IDLE;
      done_n        = 1'b0;
      inj_delay_n   = inj_delay_q;
      attempts_n    = attempts_q;
      found_n       = found_q;
      found_delay_n = found_delay_q;
    end
  end

  assign INJ_FIRE    = (state == S_FIRE);
  assign BUSY        = (state != S_IDLE);
  assign INJ_DELAY   = inj_delay_q;
  assign DONE        = done_q;
  assign FOUND       = found_q;
  assign FOUND_DELAY = found_delay_q;
  assign ATTEMPTS    = attempts_q;

endmodule
